// File: rtl/address_bus.sv
// Registered chip-select decoder for the mapache64 CPU bus.
// Maps a 16-bit CPU address onto four memory regions and four I/O registers.
module address_bus (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_address,
  output logic        SELECT_ram,
  output logic        SELECT_vram,
  output logic        SELECT_firmware,
  output logic        SELECT_rom,
  output logic        SELECT_in_vblank,
  output logic        SELECT_clr_vblank_irq,
  output logic        SELECT_controller_1,
  output logic        SELECT_controller_2
);

  // Bit order: ram, vram, firmware, rom, in_vblank, clr_vblank_irq, ctrl_1, ctrl_2
  logic [7:0] sel_d;
  logic [7:0] sel_q;

  // Address decode into a one-hot (or all-zero) select vector.
  always_comb begin
    sel_d = 8'h00;
    if (cpu_address[15]) begin
      sel_d = 8'b0001_0000;
    end else if (cpu_address[14:12] == 3'b111) begin
      // 0x7000-0x7FFF: only the first four words are mapped.
      if (cpu_address[11:2] == 10'd0) begin
        case (cpu_address[1:0])
          2'd0:    sel_d = 8'b0000_1000;
          2'd1:    sel_d = 8'b0000_0100;
          2'd2:    sel_d = 8'b0000_0010;
          2'd3:    sel_d = 8'b0000_0001;
          default: sel_d = 8'h00;
        endcase
      end else begin
        sel_d = 8'h00;
      end
    end else if (cpu_address[14]) begin
      sel_d = 8'b0010_0000;
    end else if (cpu_address[13:12] == 2'b11 && cpu_address[11:8] >= 4'h7) begin
      sel_d = 8'b0100_0000;
    end else begin
      sel_d = 8'b1000_0000;
    end
  end

  // Select register; loads every edge, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 8'h00;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign SELECT_ram            = sel_q[7];
  assign SELECT_vram           = sel_q[6];
  assign SELECT_firmware       = sel_q[5];
  assign SELECT_rom            = sel_q[4];
  assign SELECT_in_vblank      = sel_q[3];
  assign SELECT_clr_vblank_irq = sel_q[2];
  assign SELECT_controller_1   = sel_q[1];
  assign SELECT_controller_2   = sel_q[0];

endmodule

// File: tb/tb_address_bus.sv
// Self-checking bench for address_bus: directed boundaries, full address walk,
// randomized addresses and asynchronous reset behaviour against a range-based model.
module tb_address_bus;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_address;
  logic        SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom;
  logic        SELECT_in_vblank, SELECT_clr_vblank_irq;
  logic        SELECT_controller_1, SELECT_controller_2;

  int n_checks;
  int n_errors;

  address_bus dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cpu_address           (cpu_address),
    .SELECT_ram            (SELECT_ram),
    .SELECT_vram           (SELECT_vram),
    .SELECT_firmware       (SELECT_firmware),
    .SELECT_rom            (SELECT_rom),
    .SELECT_in_vblank      (SELECT_in_vblank),
    .SELECT_clr_vblank_irq (SELECT_clr_vblank_irq),
    .SELECT_controller_1   (SELECT_controller_1),
    .SELECT_controller_2   (SELECT_controller_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {SELECT_ram, SELECT_vram, SELECT_firmware, SELECT_rom,
            SELECT_in_vblank, SELECT_clr_vblank_irq,
            SELECT_controller_1, SELECT_controller_2};
  endfunction

  // Reference map written directly as inclusive address ranges.
  function automatic logic [7:0] ref_decode(input int a);
    logic [7:0] r;
    r = 8'h00;
    if (a >= 32'h0000 && a <= 32'h36FF) r[7] = 1'b1;
    if (a >= 32'h3700 && a <= 32'h3FFF) r[6] = 1'b1;
    if (a >= 32'h4000 && a <= 32'h6FFF) r[5] = 1'b1;
    if (a >= 32'h8000 && a <= 32'hFFFF) r[4] = 1'b1;
    if (a == 32'h7000) r[3] = 1'b1;
    if (a == 32'h7001) r[2] = 1'b1;
    if (a == 32'h7002) r[1] = 1'b1;
    if (a == 32'h7003) r[0] = 1'b1;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an address at the falling edge, check the selects just after the next rising edge.
  task automatic step(input string tag, input int a);
    logic [7:0] obs;
    @(negedge clk);
    cpu_address = a[15:0];
    @(posedge clk);
    #1;
    obs = observed();
    check_eq(tag, {24'd0, obs}, {24'd0, ref_decode(a)});
  endtask

  int dir_addr[] = '{32'h0000, 32'h36FF, 32'h3700, 32'h3FFF, 32'h4000, 32'h6FFF,
                     32'h8000, 32'hFFFF, 32'h7000, 32'h7001, 32'h7002, 32'h7003,
                     32'h7004, 32'h7FFF};

  initial begin
    logic [7:0] obs;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    cpu_address = 16'h0000;

    // Reset held across several edges, including with changing addresses.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_hold", {24'd0, observed()}, 32'd0);
      cpu_address = 16'($urandom);
    end
    @(negedge clk);
    cpu_address = 16'h0000;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_release_ram", {24'd0, observed()}, 32'h80);

    // Directed region and I/O boundaries.
    foreach (dir_addr[i]) step($sformatf("dir_%04h", dir_addr[i]), dir_addr[i]);

    // Full walk, also checking at most one select is active.
    for (int a = 0; a < 65536; a++) begin
      @(negedge clk);
      cpu_address = a[15:0];
      @(posedge clk);
      #1;
      obs = observed();
      check_eq("walk", {16'd0, a[15:0], obs}, {16'd0, a[15:0], ref_decode(a)});
      check_eq("onehot", {31'd0, ($countones(obs) <= 1)}, 32'd1);
    end

    // Randomized back-to-back addresses.
    for (int i = 0; i < 2000; i++) step("rand", int'($urandom_range(0, 65535)));

    // Asynchronous reset between edges.
    step("pre_reset_rom", 32'h8000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", {24'd0, observed()}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("reset_mid_hold", {24'd0, observed()}, 32'd0);
    @(negedge clk);
    cpu_address = 16'h7002;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_reset_ctrl1", {24'd0, observed()}, 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
